// File: rtl/usb_data_buffer.sv
// usb_data_buffer: shared endpoint byte FIFO between the AHB-lite register block and the USB
// RX/TX packet engines. First-word fall-through head, live occupancy, sticky error flags.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   clear                 synchronous flush of pointers, count and error flags
//   store_tx_data/tx_data AHB-side push request and byte
//   get_rx_data/rx_data   AHB-side pop request and head byte
//   store_rx_packet_data/rx_packet_data  USB-RX push request and byte
//   get_tx_packet_data/tx_packet_data    USB-TX pop request and head byte
//   buffer_occupancy/empty/full          status derived from the registered count
//   overflow_err/underflow_err           sticky flags for dropped pushes / ignored pops
module usb_data_buffer #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     store_tx_data,
  input  logic [7:0]               tx_data,
  input  logic                     get_rx_data,
  output logic [7:0]               rx_data,
  input  logic                     store_rx_packet_data,
  input  logic [7:0]               rx_packet_data,
  input  logic                     get_tx_packet_data,
  output logic [7:0]               tx_packet_data,
  output logic [$clog2(DEPTH):0]   buffer_occupancy,
  output logic                     buffer_empty,
  output logic                     buffer_full,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [OccW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic       push, pop, push_acc, pop_acc, empty, full;
  logic [7:0] wdata, head;

  assign empty = (count_q == '0);
  assign full  = (count_q == OccFull);
  assign push  = store_rx_packet_data | store_tx_data;
  assign pop   = get_rx_data | get_tx_packet_data;
  // USB RX wins a same-cycle push collision; the AHB byte is dropped.
  assign wdata = store_rx_packet_data ? rx_packet_data : tx_data;

  assign pop_acc  = pop & ~empty;
  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign push_acc = push & (~full | pop_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (push_acc) wptr_d = wptr_q + PtrOne;
      if (pop_acc)  rptr_d = rptr_q + PtrOne;
      count_d = count_q + OccW'(push_acc) - OccW'(pop_acc);
      if ((store_rx_packet_data & store_tx_data) | (push & ~push_acc)) ovf_d = 1'b1;
      if (pop & empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage has no reset; validity is tracked solely by the count.
  always_ff @(posedge clk) begin
    if (push_acc && !clear) mem[wptr_q] <= wdata;
  end

  assign head             = empty ? 8'h00 : mem[rptr_q];
  assign rx_data          = head;
  assign tx_packet_data   = head;
  assign buffer_occupancy = count_q;
  assign buffer_empty     = empty;
  assign buffer_full      = full;
  assign overflow_err     = ovf_q;
  assign underflow_err    = unf_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
module tb_usb_data_buffer;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_rx_data;
  logic [7:0] rx_data;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       buffer_empty;
  logic       buffer_full;
  logic       overflow_err;
  logic       underflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a byte queue plus two sticky flags.
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  usb_data_buffer #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .buffer_empty         (buffer_empty),
    .buffer_full          (buffer_full),
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_head;
    exp_head = (q.size() > 0) ? q[0] : 8'h00;
    check({tag, ".occ"},   buffer_occupancy, q.size());
    check({tag, ".empty"}, buffer_empty, q.size() == 0);
    check({tag, ".full"},  buffer_full, q.size() == DEPTH);
    check({tag, ".ovf"},   overflow_err, m_ovf);
    check({tag, ".unf"},   underflow_err, m_unf);
    check({tag, ".rxd"},   rx_data, exp_head);
    check({tag, ".txd"},   tx_packet_data, exp_head);
  endtask

  // Called just after a falling edge: drive inputs, check, advance model, clock once.
  task automatic cycle(input string tag, input bit srx, input logic [7:0] drx, input bit stx,
                       input logic [7:0] dtx, input bit grx, input bit gtx, input bit clr);
    bit was_empty, was_full, pop, push;
    store_rx_packet_data = srx;
    rx_packet_data       = drx;
    store_tx_data        = stx;
    tx_data              = dtx;
    get_rx_data          = grx;
    get_tx_packet_data   = gtx;
    clear                = clr;
    #1;
    check_state(tag);
    if (clr) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      pop  = grx | gtx;
      push = srx | stx;
      if (srx && stx) m_ovf = 1;
      if (pop) begin
        if (was_empty) m_unf = 1;
        else void'(q.pop_front());
      end
      if (push) begin
        if (was_full && !(pop && !was_empty)) m_ovf = 1;
        else q.push_back(srx ? drx : dtx);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle("idle", 0, 8'h00, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    logic [7:0] seq [4];
    int pp;
    seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hD4;
    n_rst = 1'b0; clear = 0; store_tx_data = 0; tx_data = 0; get_rx_data = 0;
    store_rx_packet_data = 0; rx_packet_data = 0; get_tx_packet_data = 0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    #1;
    check_state("reset");
    @(negedge clk);

    // Four pushes then four pops with explicit head values.
    for (int i = 0; i < 4; i++) cycle("push4", 0, 8'h00, 1, seq[i], 0, 0, 0);
    check("push4.occ_final", buffer_occupancy, 4);
    for (int i = 0; i < 4; i++) begin
      #1 check("pop4.head", tx_packet_data, seq[i]);
      cycle("pop4", 0, 8'h00, 0, 8'h00, 0, 1, 0);
    end
    #1 check("pop4.empty", buffer_empty, 1);

    // Fill, overflow, drain.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 0, 8'h00, 1, 8'(i), 0, 0, 0);
    cycle("ovf_push", 0, 8'h00, 1, 8'hFF, 0, 0, 0);
    check("ovf.full", buffer_full, 1);
    check("ovf.flag", overflow_err, 1);
    check("ovf.occ", buffer_occupancy, 64);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 0, 8'h00, 0, 8'h00, 0, 1, 0);
    cycle("clr1", 0, 8'h00, 0, 8'h00, 0, 0, 1);

    // Pointer wrap.
    for (int i = 0; i < DEPTH; i++) cycle("wfill", 1, 8'(i + 1), 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle("wpop", 0, 8'h00, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle("wpush", 0, 8'h00, 1, 8'(8'hC0 + i), 0, 0, 0);
    #1 check("wrap.head", rx_data, 8'd11);
    for (int i = 0; i < DEPTH; i++) cycle("wdrain", 0, 8'h00, 0, 8'h00, 1, 0, 0);

    // Pop while empty with a same-cycle push.
    cycle("unf", 1, 8'h5A, 0, 8'h00, 1, 0, 0);
    check("unf.flag", underflow_err, 1);
    check("unf.rxd", rx_data, 8'h5A);
    cycle("unf_pop", 0, 8'h00, 0, 8'h00, 1, 0, 0);

    // Dual push collision.
    cycle("dual", 1, 8'h11, 1, 8'h22, 0, 0, 0);
    check("dual.head", rx_data, 8'h11);
    check("dual.occ", buffer_occupancy, 1);

    // Clear with flags set and a same-cycle push.
    for (int i = 0; i < 19; i++) cycle("c20", 0, 8'h00, 1, 8'(i), 0, 0, 0);
    cycle("clr_push", 1, 8'h77, 0, 8'h00, 0, 0, 1);
    check("clr.occ", buffer_occupancy, 0);
    check("clr.rxd", rx_data, 8'h00);
    check("clr.ovf", overflow_err, 0);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 20; i++) cycle("rburst", 0, 8'h00, 1, 8'(i), 0, 0, 0);
    cycle("rset_ovf", 1, 8'h01, 1, 8'h02, 0, 0, 0);
    store_tx_data = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    check("arst.occ", buffer_occupancy, 0);
    check("arst.empty", buffer_empty, 1);
    check("arst.ovf", overflow_err, 0);
    check("arst.rxd", rx_data, 8'h00);
    store_tx_data = 1'b0;
    do_reset();

    // Randomized traffic with phases biased toward filling or draining.
    for (int ph = 0; ph < 6; ph++) begin
      pp = (ph % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 300; i++) begin
        cycle("rand",
              $urandom_range(0, 99) < pp, 8'($urandom_range(0, 255)),
              $urandom_range(0, 99) < pp / 2, 8'($urandom_range(0, 255)),
              $urandom_range(0, 99) < (100 - pp) / 2, $urandom_range(0, 99) < (100 - pp) / 2,
              $urandom_range(0, 149) == 0);
      end
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
